fire_sequencer: RTL and testbench
=================================

# fire_sequencer

Parametrised multi-channel trigger generator: after an accepted `start` it waits a programmable delay, then drives `NCH` fire outputs at per-channel cycle offsets within a repeating period, for a programmed number of periods or until stopped. It is the synthesizable generalisation of the single delayed `fire` assertion used to launch measurements, and sits between the control logic and the skew-measurement datapaths it triggers.

## Interface
- `NCH`, 4: number of fire channels.
- `CNT_W`, 16: width of delay, offset, period and shot counters.
- `FIRE_PULSE`, 0: 0 = level mode (fire bits stay set); 1 = pulse mode (one-cycle pulse per period).

- `clk1`  in  1  clock.
- `resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  launch request, sampled in IDLE only.
- `stop`  in  1  abort, sampled in any state.
- `cfg_delay`  in  CNT_W  cycles before the first period.
- `cfg_period`  in  CNT_W  period length; 0 means 2^CNT_W.
- `cfg_shots`  in  CNT_W  number of periods; 0 means unlimited.
- `cfg_offset`  in  NCH×CNT_W  per-channel fire offset within the period.
- `fire`  out  NCH  fire outputs.
- `busy`  out  1  high in ARM or RUN.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, ARM, RUN. Reset: state IDLE; `fire`, `busy`, `done` and all counters 0.
- IDLE: `start` && !`stop` latches all cfg inputs. Latched delay > 0 → ARM with delay counter 0; delay = 0 → RUN with t = 0. `busy` = 1 from that edge. In level mode `fire` clears on that edge.
- ARM: increment the delay counter; on the edge where it reaches delay−1, go to RUN with t = 0.
- RUN: t counts 0..period−1, then wraps to 0 and increments the shot counter. If shots ≠ 0 and the period just completed is the last, go to IDLE on that edge, with `busy` ← 0 and `done` ← 1 for one cycle.
- Channel i: when RUN and t == offset[i], `fire[i]` is set on the next edge. Level mode holds it until stop or the next accepted start. Pulse mode holds it for one cycle only.
- Any offset ≥ period never fires. Pulse mode: offset = period−1 in the last period still pulses, coincident with `done`.
- `stop` in ARM or RUN: go to IDLE next edge, with `busy` ← 0, `fire` ← 0 and no `done`. `stop` in IDLE clears a held level-mode `fire`.
- `start` in ARM or RUN is ignored. `start` and `stop` in the same cycle: `stop` wins.
- Latched config is immune to cfg changes while busy.

## Timing
- Start sampled at edge E: t = 0 holds after edge E+delay. `fire[i]` is high after edge E+delay+offset[i]+1.
- `done` is high after edge E+delay+shots×period.
- All outputs are registered; there is no combinational input→output path.
- `resetn` low forces every output to 0 immediately, mid-operation included. After release the block stays in IDLE until a new `start`.

## Configuration
- `FIRE_SEQ_SHOTCNT_EN`: defined → extra outputs `shot_cnt` (CNT_W, completed periods of the current/last run, cleared on start) and `phase` (CNT_W, current t, 0 outside RUN).
- Undefined → these ports and their registers are absent; all other behaviour is identical.

## Structure
- `fire_seq_pkg`: state enum (IDLE, ARM, RUN), `FIRE_LEVEL`/`FIRE_PULSE` mode constants, and a period-decode helper that maps 0 to 2^CNT_W.
- Sub-module `fire_seq_channel`: a per-channel offset register, comparator and fire output register, instantiated `NCH` times via generate.
- The FSM and the delay, t and shot counters stay in the top module.

## Test plan
- Level, NCH=4, CNT_W=8, delay=3, offsets {0,2,5,9}, period=8, shots=1, start at edge 0 → `fire[0]` high after edge 4, `fire[1]` after edge 6, `fire[2]` after edge 9, `fire[3]` never; `done` after edge 11; fire bits remain high.
- Pulse, delay=0, period=4, shots=3, offset[0]=1 → `fire[0]` one-cycle pulses after edges 2, 6 and 10; `done` pulse after edge 12; `busy` 0 afterwards.
- shots=0, period=5 → pulses continue indefinitely; `stop` at edge 20 → `busy` and `fire` 0 after edge 20; `done` never asserts.
- `start` re-asserted while busy → no restart and no timing shift. `start` and `stop` together in IDLE → remains IDLE.
- `resetn` low mid-RUN → all outputs 0 immediately. After release, no fire until a new `start`.
- period=0, CNT_W=8, offset[0]=255, shots=1 → one pulse after edge 256; `done` after edge 256.

Source files
------------

// File: rtl/fire_seq_pkg.sv
// ---------------------------------------------------------------------------
// fire_seq_pkg
// Shared definitions for the fire sequencer:
//   fire_state_t  - sequencer states (IDLE, ARM, RUN)
//   FIRE_LEVEL    - fire bits stay set once reached
//   FIRE_PULSE    - fire bits pulse for one cycle per period
//   period_len()  - decodes a programmed period, where 0 stands for 2^cnt_w
// ---------------------------------------------------------------------------
package fire_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } fire_state_t;

   localparam int FIRE_LEVEL = 0;
   localparam int FIRE_PULSE = 1;

   // The period register has no spare code for 2^cnt_w, so 0 is reused for
   // the longest possible period. The result is one bit wider than the input.
   function automatic logic [32:0] period_len(input logic [31:0] period,
                                              input int unsigned cnt_w);
      if (period == 32'd0) begin
         return 33'd1 << cnt_w;
      end
      return {1'b0, period};
   endfunction

endpackage

// File: rtl/fire_seq_channel.sv
// ---------------------------------------------------------------------------
// fire_seq_channel
// One fire channel: holds the channel's offset and raises its fire bit on
// the edge after the period phase reaches that offset.
// Ports:
//   clk1, resetn  clock, asynchronous active-low reset
//   load          accepted start: latch cfg_offset and clear fire
//   clear         stop request: clear fire
//   run           sequencer is in RUN
//   t             current phase within the period
//   cfg_offset    offset to latch on load
//   fire          registered fire output
// Parameters: CNT_W counter width, MODE FIRE_LEVEL or FIRE_PULSE.
// ---------------------------------------------------------------------------
module fire_seq_channel
   import fire_seq_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int MODE  = FIRE_LEVEL
) (
   input  logic             clk1,
   input  logic             resetn,
   input  logic             load,
   input  logic             clear,
   input  logic             run,
   input  logic [CNT_W-1:0] t,
   input  logic [CNT_W-1:0] cfg_offset,
   output logic             fire
);

   logic [CNT_W-1:0] offset_q;

   // Offset capture and fire register. Stop and a fresh start both clear the
   // bit and take priority over a coincident match, so a stop on the match
   // cycle never leaks a pulse. Offsets beyond the period simply never match
   // because t never gets there. In pulse mode any non-matching cycle drops
   // the bit again.
   always_ff @(posedge clk1 or negedge resetn) begin
      if (!resetn) begin
         offset_q <= '0;
         fire     <= 1'b0;
      end else begin
         if (load) begin
            offset_q <= cfg_offset;
         end
         if (clear || load) begin
            fire <= 1'b0;
         end else if (run && (t == offset_q)) begin
            fire <= 1'b1;
         end else if (MODE == FIRE_PULSE) begin
            fire <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fire_sequencer.sv
// ---------------------------------------------------------------------------
// fire_sequencer
// Multi-channel trigger generator. An accepted start latches the
// configuration, waits cfg_delay cycles, then runs periods of cfg_period
// cycles in which channel i fires when the phase equals its offset. It stops
// after cfg_shots periods (0 = run until stopped) or on stop.
// Ports:
//   clk1, resetn  clock, asynchronous active-low reset
//   start         launch request, honoured only in IDLE
//   stop          abort, honoured in any state, wins over start
//   cfg_delay     cycles from start to the first period
//   cfg_period    period length, 0 = 2^CNT_W
//   cfg_shots     number of periods, 0 = unlimited
//   cfg_offset    per-channel offsets, channel i in [i*CNT_W +: CNT_W]
//   fire          per-channel fire outputs
//   busy          high in ARM or RUN
//   done          one-cycle pulse on normal completion
// Optional build macro FIRE_SEQ_SHOTCNT_EN adds:
//   shot_cnt      completed periods of the current or last run
//   phase         current phase t, 0 outside RUN
// Parameters: NCH channels, CNT_W counter width (max 32),
//             FIRE_PULSE 0 = level mode, 1 = pulse mode.
// ---------------------------------------------------------------------------
module fire_sequencer #(
   parameter int NCH        = 4,
   parameter int CNT_W      = 16,
   parameter int FIRE_PULSE = fire_seq_pkg::FIRE_LEVEL
) (
   input  logic                 clk1,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 stop,
   input  logic [CNT_W-1:0]     cfg_delay,
   input  logic [CNT_W-1:0]     cfg_period,
   input  logic [CNT_W-1:0]     cfg_shots,
   input  logic [NCH*CNT_W-1:0] cfg_offset,
   output logic [NCH-1:0]       fire,
   output logic                 busy,
   output logic                 done
`ifdef FIRE_SEQ_SHOTCNT_EN
   ,
   output logic [CNT_W-1:0]     shot_cnt,
   output logic [CNT_W-1:0]     phase
`endif
);

   import fire_seq_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   fire_state_t      state_q, state_d;
   logic [CNT_W-1:0] delay_q, period_last_q, shots_q;
   logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
   logic [CNT_W-1:0] t_q, t_d;
   logic [CNT_W-1:0] shot_q, shot_d;
   logic             busy_d, done_d;
   logic             accept;
   logic             run;

   assign run = (state_q == RUN);

   // Next-state logic. The delay counter counts 0..delay-1 in ARM, the phase
   // t counts 0..period-1 in RUN, and the shot counter advances on every
   // period wrap. t is forced back to 0 whenever RUN is left so that it reads
   // as 0 outside RUN. The last-shot test uses the count before it advances,
   // so completion lands exactly on the wrap edge of the final period.
   always_comb begin
      state_d     = state_q;
      delay_cnt_d = delay_cnt_q;
      t_d         = t_q;
      shot_d      = shot_q;
      busy_d      = busy;
      done_d      = 1'b0;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               accept      = 1'b1;
               busy_d      = 1'b1;
               delay_cnt_d = '0;
               t_d         = '0;
               shot_d      = '0;
               state_d     = (cfg_delay != '0) ? ARM : RUN;
            end
         end
         ARM: begin
            if (stop) begin
               state_d     = IDLE;
               busy_d      = 1'b0;
               delay_cnt_d = '0;
            end else if (delay_cnt_q == (delay_q - CNT_ONE)) begin
               state_d     = RUN;
               delay_cnt_d = '0;
               t_d         = '0;
            end else begin
               delay_cnt_d = delay_cnt_q + CNT_ONE;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               t_d     = '0;
            end else if (t_q == period_last_q) begin
               t_d    = '0;
               shot_d = shot_q + CNT_ONE;
               if ((shots_q != '0) && (shot_q == (shots_q - CNT_ONE))) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               t_d = t_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            t_d     = '0;
         end
      endcase
   end

   // State, counters and the busy/done outputs are all plain registers so
   // no input can reach an output combinationally.
   always_ff @(posedge clk1 or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         delay_cnt_q <= '0;
         t_q         <= '0;
         shot_q      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         delay_cnt_q <= delay_cnt_d;
         t_q         <= t_d;
         shot_q      <= shot_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

   // Configuration is captured only on an accepted start, so the cfg inputs
   // may change freely while a run is in progress. The period is stored as
   // its last phase value, which also turns the 0 = 2^CNT_W case into an
   // all-ones terminal count.
   always_ff @(posedge clk1 or negedge resetn) begin
      if (!resetn) begin
         delay_q       <= '0;
         period_last_q <= '0;
         shots_q       <= '0;
      end else if (accept) begin
         delay_q       <= cfg_delay;
         period_last_q <= CNT_W'(period_len(32'(cfg_period), CNT_W) - 33'd1);
         shots_q       <= cfg_shots;
      end
   end

   // One comparator/fire register per channel, all sharing the phase counter.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      fire_seq_channel #(
         .CNT_W (CNT_W),
         .MODE  (FIRE_PULSE)
      ) u_ch (
         .clk1       (clk1),
         .resetn     (resetn),
         .load       (accept),
         .clear      (stop),
         .run        (run),
         .t          (t_q),
         .cfg_offset (cfg_offset[i*CNT_W +: CNT_W]),
         .fire       (fire[i])
      );
   end

`ifdef FIRE_SEQ_SHOTCNT_EN
   assign shot_cnt = shot_q;
   assign phase    = t_q;
`endif

endmodule

// File: tb/tb_fire_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fire_sequencer
// Directed bench for fire_sequencer with NCH=4, CNT_W=8. A level-mode and a
// pulse-mode instance share the same stimulus. "after edge k" means 1 time
// unit after the k-th rising edge counted from the start edge (edge 0).
// ---------------------------------------------------------------------------
module tb_fire_sequencer;

   localparam int NCH   = 4;
   localparam int CNT_W = 8;

   logic                 clk1 = 1'b0;
   logic                 resetn;
   logic                 start;
   logic                 stop;
   logic [CNT_W-1:0]     cfg_delay;
   logic [CNT_W-1:0]     cfg_period;
   logic [CNT_W-1:0]     cfg_shots;
   logic [NCH*CNT_W-1:0] cfg_offset;
   logic [NCH-1:0]       fire_lvl, fire_pls;
   logic                 busy_lvl, done_lvl, busy_pls, done_pls;
`ifdef FIRE_SEQ_SHOTCNT_EN
   logic [CNT_W-1:0]     shot_lvl, phase_lvl, shot_pls, phase_pls;
`endif

   int pass_count  = 0;
   int check_count = 0;
   int fail_count  = 0;
   int edge_no     = 0;

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk1 = ~clk1;

   fire_sequencer #(.NCH(NCH), .CNT_W(CNT_W), .FIRE_PULSE(0)) dut_lvl (
      .clk1       (clk1),
      .resetn     (resetn),
      .start      (start),
      .stop       (stop),
      .cfg_delay  (cfg_delay),
      .cfg_period (cfg_period),
      .cfg_shots  (cfg_shots),
      .cfg_offset (cfg_offset),
      .fire       (fire_lvl),
      .busy       (busy_lvl),
      .done       (done_lvl)
`ifdef FIRE_SEQ_SHOTCNT_EN
      ,
      .shot_cnt   (shot_lvl),
      .phase      (phase_lvl)
`endif
   );

   fire_sequencer #(.NCH(NCH), .CNT_W(CNT_W), .FIRE_PULSE(1)) dut_pls (
      .clk1       (clk1),
      .resetn     (resetn),
      .start      (start),
      .stop       (stop),
      .cfg_delay  (cfg_delay),
      .cfg_period (cfg_period),
      .cfg_shots  (cfg_shots),
      .cfg_offset (cfg_offset),
      .fire       (fire_pls),
      .busy       (busy_pls),
      .done       (done_pls)
`ifdef FIRE_SEQ_SHOTCNT_EN
      ,
      .shot_cnt   (shot_pls),
      .phase      (phase_pls)
`endif
   );

   // Drive every control and configuration input in one go.
   task automatic applyStimulus(input logic s, input logic p,
                                input logic [7:0] d, input logic [7:0] per,
                                input logic [7:0] sh, input logic [31:0] offs);
      start      = s;
      stop       = p;
      cfg_delay  = d;
      cfg_period = per;
      cfg_shots  = sh;
      cfg_offset = offs;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance to 1 time unit after the given edge number.
   task automatic advanceTo(input int k);
      while (edge_no < k) begin
         @(posedge clk1);
         #1;
         edge_no++;
      end
   endtask

   // Issue a start (or start+stop) on the next edge, which becomes edge 0.
   task automatic launch();
      @(posedge clk1);
      #1;
      edge_no = 0;
   endtask

   initial begin
      $display("[TB] reset");
      resetn = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 32'h0);
      @(posedge clk1);
      #1;
      checkOutput("rst_fire_lvl", 32'(fire_lvl), 32'h0);
      checkOutput("rst_busy_lvl", 32'(busy_lvl), 32'h0);
      checkOutput("rst_done_lvl", 32'(done_lvl), 32'h0);
      checkOutput("rst_fire_pls", 32'(fire_pls), 32'h0);
      checkOutput("rst_busy_pls", 32'(busy_pls), 32'h0);
      checkOutput("rst_done_pls", 32'(done_pls), 32'h0);
      resetn = 1'b1;
      repeat (2) @(posedge clk1);
      #1;

      $display("[TB] level mode, delay 3, period 8, one shot");
      applyStimulus(1'b1, 1'b0, 8'd3, 8'd8, 8'd1, 32'h09050200);
      launch();
      checkOutput("t1_busy_e0", 32'(busy_lvl), 32'h1);
      checkOutput("t1_fire_e0", 32'(fire_lvl), 32'h0);
      applyStimulus(1'b0, 1'b0, 8'd1, 8'd2, 8'd5, 32'h0);
      advanceTo(3);  checkOutput("t1_fire_e3", 32'(fire_lvl), 32'h0);
      advanceTo(4);  checkOutput("t1_fire_e4", 32'(fire_lvl), 32'h1);
      advanceTo(5);  checkOutput("t1_fire_e5", 32'(fire_lvl), 32'h1);
      advanceTo(6);  checkOutput("t1_fire_e6", 32'(fire_lvl), 32'h3);
      advanceTo(8);  checkOutput("t1_fire_e8", 32'(fire_lvl), 32'h3);
      advanceTo(9);  checkOutput("t1_fire_e9", 32'(fire_lvl), 32'h7);
      advanceTo(10);
      checkOutput("t1_done_e10", 32'(done_lvl), 32'h0);
      checkOutput("t1_busy_e10", 32'(busy_lvl), 32'h1);
      advanceTo(11);
      checkOutput("t1_done_e11", 32'(done_lvl), 32'h1);
      checkOutput("t1_busy_e11", 32'(busy_lvl), 32'h0);
      checkOutput("t1_fire_e11", 32'(fire_lvl), 32'h7);
      advanceTo(12);
      checkOutput("t1_done_e12", 32'(done_lvl), 32'h0);
      checkOutput("t1_fire_e12", 32'(fire_lvl), 32'h7);

      $display("[TB] pulse mode, delay 0, period 4, three shots, start while busy");
      applyStimulus(1'b1, 1'b0, 8'd0, 8'd4, 8'd3, 32'h04030001);
      launch();
      checkOutput("t2_busy_e0", 32'(busy_pls), 32'h1);
      checkOutput("t2_fire_pls_e0", 32'(fire_pls), 32'h0);
      checkOutput("t2_fire_lvl_cleared", 32'(fire_lvl), 32'h0);
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd4, 8'd3, 32'h04030001);
      advanceTo(1);  checkOutput("t2_fire_e1", 32'(fire_pls), 32'h2);
      advanceTo(2);  checkOutput("t2_fire_e2", 32'(fire_pls), 32'h1);
      advanceTo(4);  checkOutput("t2_fire_e4", 32'(fire_pls), 32'h4);
      applyStimulus(1'b1, 1'b0, 8'd7, 8'd3, 8'd1, 32'h0);
      advanceTo(5);
      checkOutput("t2_restart_fire_e5", 32'(fire_pls), 32'h2);
      checkOutput("t2_restart_busy_e5", 32'(busy_pls), 32'h1);
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd4, 8'd3, 32'h04030001);
      advanceTo(6);  checkOutput("t2_fire_e6", 32'(fire_pls), 32'h1);
      advanceTo(10); checkOutput("t2_fire_e10", 32'(fire_pls), 32'h1);
      advanceTo(11);
      checkOutput("t2_fire_e11", 32'(fire_pls), 32'h0);
      checkOutput("t2_done_e11", 32'(done_pls), 32'h0);
      advanceTo(12);
      checkOutput("t2_fire_e12", 32'(fire_pls), 32'h4);
      checkOutput("t2_done_e12", 32'(done_pls), 32'h1);
      checkOutput("t2_busy_e12", 32'(busy_pls), 32'h0);
      checkOutput("t2_done_lvl_e12", 32'(done_lvl), 32'h1);
      checkOutput("t2_fire_lvl_e12", 32'(fire_lvl), 32'h7);
      advanceTo(13);
      checkOutput("t2_fire_e13", 32'(fire_pls), 32'h0);
      checkOutput("t2_done_e13", 32'(done_pls), 32'h0);
      checkOutput("t2_busy_e13", 32'(busy_pls), 32'h0);

      $display("[TB] start and stop together in IDLE");
      applyStimulus(1'b1, 1'b1, 8'd0, 8'd4, 8'd3, 32'h04030001);
      launch();
      checkOutput("t3_busy_lvl", 32'(busy_lvl), 32'h0);
      checkOutput("t3_busy_pls", 32'(busy_pls), 32'h0);
      checkOutput("t3_fire_lvl", 32'(fire_lvl), 32'h0);
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd4, 8'd3, 32'h04030001);
      advanceTo(2);
      checkOutput("t3_busy_pls_e2", 32'(busy_pls), 32'h0);
      checkOutput("t3_fire_pls_e2", 32'(fire_pls), 32'h0);

      $display("[TB] unlimited shots, period 5, stop at edge 20");
      applyStimulus(1'b1, 1'b0, 8'd0, 8'd5, 8'd0, 32'h07050402);
      launch();
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd5, 8'd0, 32'h07050402);
      advanceTo(3);  checkOutput("t4_fire_e3", 32'(fire_pls), 32'h1);
      advanceTo(5);
      checkOutput("t4_fire_e5", 32'(fire_pls), 32'h2);
      checkOutput("t4_done_e5", 32'(done_pls), 32'h0);
      advanceTo(13); checkOutput("t4_fire_e13", 32'(fire_pls), 32'h1);
      advanceTo(15);
      checkOutput("t4_fire_e15", 32'(fire_pls), 32'h2);
      checkOutput("t4_done_e15", 32'(done_pls), 32'h0);
      checkOutput("t4_busy_e15", 32'(busy_pls), 32'h1);
      advanceTo(18); checkOutput("t4_fire_e18", 32'(fire_pls), 32'h1);
      advanceTo(19);
      checkOutput("t4_fire_e19", 32'(fire_pls), 32'h0);
      checkOutput("t4_fire_lvl_e19", 32'(fire_lvl), 32'h3);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd5, 8'd0, 32'h07050402);
      advanceTo(20);
      checkOutput("t4_stop_busy_pls", 32'(busy_pls), 32'h0);
      checkOutput("t4_stop_fire_pls", 32'(fire_pls), 32'h0);
      checkOutput("t4_stop_done_pls", 32'(done_pls), 32'h0);
      checkOutput("t4_stop_busy_lvl", 32'(busy_lvl), 32'h0);
      checkOutput("t4_stop_fire_lvl", 32'(fire_lvl), 32'h0);
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd5, 8'd0, 32'h07050402);
      advanceTo(21);
      checkOutput("t4_done_e21", 32'(done_pls), 32'h0);
      checkOutput("t4_fire_e21", 32'(fire_pls), 32'h0);

      $display("[TB] reset in the middle of RUN");
      applyStimulus(1'b1, 1'b0, 8'd1, 8'd8, 8'd0, 32'h0);
      launch();
      applyStimulus(1'b0, 1'b0, 8'd1, 8'd8, 8'd0, 32'h0);
      advanceTo(2);
      checkOutput("t5_fire_lvl_e2", 32'(fire_lvl), 32'hF);
      checkOutput("t5_fire_pls_e2", 32'(fire_pls), 32'hF);
      advanceTo(4);
      checkOutput("t5_fire_lvl_e4", 32'(fire_lvl), 32'hF);
      checkOutput("t5_busy_lvl_e4", 32'(busy_lvl), 32'h1);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("t5_rst_fire_lvl", 32'(fire_lvl), 32'h0);
      checkOutput("t5_rst_busy_lvl", 32'(busy_lvl), 32'h0);
      checkOutput("t5_rst_busy_pls", 32'(busy_pls), 32'h0);
      checkOutput("t5_rst_done_pls", 32'(done_pls), 32'h0);
      @(posedge clk1);
      #1;
      resetn = 1'b1;
      repeat (10) @(posedge clk1);
      #1;
      checkOutput("t5_post_fire_lvl", 32'(fire_lvl), 32'h0);
      checkOutput("t5_post_fire_pls", 32'(fire_pls), 32'h0);
      checkOutput("t5_post_busy_lvl", 32'(busy_lvl), 32'h0);
      checkOutput("t5_post_busy_pls", 32'(busy_pls), 32'h0);

      $display("[TB] period 0 (256 cycles), offset 255, one shot");
      applyStimulus(1'b1, 1'b0, 8'd0, 8'd0, 8'd1, 32'h000000FF);
      launch();
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd1, 32'h000000FF);
      advanceTo(255);
      checkOutput("t6_fire_e255", 32'(fire_pls), 32'h0);
      checkOutput("t6_busy_e255", 32'(busy_pls), 32'h1);
      checkOutput("t6_done_e255", 32'(done_pls), 32'h0);
      advanceTo(256);
      checkOutput("t6_fire_e256", 32'(fire_pls), 32'h1);
      checkOutput("t6_done_e256", 32'(done_pls), 32'h1);
      checkOutput("t6_busy_e256", 32'(busy_pls), 32'h0);
      checkOutput("t6_done_lvl_e256", 32'(done_lvl), 32'h1);
      checkOutput("t6_fire_lvl_e256", 32'(fire_lvl), 32'hF);
      advanceTo(257);
      checkOutput("t6_fire_e257", 32'(fire_pls), 32'h0);
      checkOutput("t6_done_e257", 32'(done_pls), 32'h0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
